// File: rtl/ahb_sdram_bridge_if.sv
// AHB-Lite slave bus plus request/acknowledge link toward the SDRAM core.
interface ahb_sdram_bridge_if #(
    parameter int HAW      = 32,
    parameter int SDRAM_AW = 24
);
    // AHB-Lite side
    logic                hsel;
    logic [HAW-1:0]      haddr;
    logic                hwrite;
    logic [1:0]          htrans;
    logic [2:0]          hsize;
    logic [31:0]         hwdata;
    logic                hready;
    logic [31:0]         hrdata;
    logic                hreadyout;
    logic                hresp;
    // SDRAM core side
    logic                mem_req;
    logic                mem_we;
    logic [SDRAM_AW-3:0] mem_addr;
    logic [3:0]          mem_be;
    logic [31:0]         mem_wdata;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [31:0]         mem_rdata;

    modport slave (
        input  hsel, haddr, hwrite, htrans, hsize, hwdata, hready,
        input  mem_ack, mem_rvalid, mem_rdata,
        output hrdata, hreadyout, hresp,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output hsel, haddr, hwrite, htrans, hsize, hwdata, hready,
        output mem_ack, mem_rvalid, mem_rdata,
        input  hrdata, hreadyout, hresp,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/ahb_sdram_bridge.sv
// AHB-Lite slave that turns single transfers into held requests to the
// SDRAM controller core, inserting wait states until the core finishes and
// answering misaligned / oversized transfers with a two-cycle ERROR.
module ahb_sdram_bridge #(
    parameter int HAW      = 32,
    parameter int SDRAM_AW = 24
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    ahb_sdram_bridge_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, WDATA, REQ, RWAIT, ERR1, ERR2} state_t;

    state_t              state, state_n;
    logic                hreadyout_q, hreadyout_n;
    logic                hresp_q, hresp_n;
    logic [31:0]         hrdata_q, hrdata_n;
    logic                mem_req_q, mem_req_n;
    logic                mem_we_q, mem_we_n;
    logic [SDRAM_AW-3:0] mem_addr_q, mem_addr_n;
    logic [3:0]          mem_be_q, mem_be_n;
    logic [31:0]         mem_wdata_q, mem_wdata_n;

    logic                accept;
    logic                illegal;
    logic [3:0]          be_dec;
    logic                unused_bits;

    // Address bits above the SDRAM window alias; htrans[0] (SEQ vs NONSEQ) is irrelevant for singles.
    assign unused_bits = ^{bus.haddr[HAW-1:SDRAM_AW], bus.htrans[0]};

    assign accept  = bus.hsel & bus.hready & bus.htrans[1];
    assign illegal = (bus.hsize > 3'd2) ||
                     (bus.hsize == 3'd1 && bus.haddr[0]) ||
                     (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);

    // Byte-lane decode for the address-phase size and offset.
    always_comb begin
        case (bus.hsize)
            3'd0:    be_dec = 4'b0001 << bus.haddr[1:0];
            3'd1:    be_dec = bus.haddr[1] ? 4'b1100 : 4'b0011;
            default: be_dec = 4'b1111;
        endcase
    end

    // Next state and next values of every registered output; holds by default.
    always_comb begin
        state_n     = state;
        hreadyout_n = hreadyout_q;
        hresp_n     = hresp_q;
        hrdata_n    = hrdata_q;
        mem_req_n   = mem_req_q;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_be_n    = mem_be_q;
        mem_wdata_n = mem_wdata_q;
        case (state)
            IDLE, ERR2: begin
                // Ready states: a new address phase may land here, including
                // the completing cycle of the previous transfer.
                state_n     = IDLE;
                hreadyout_n = 1'b1;
                hresp_n     = 1'b0;
                if (accept) begin
                    mem_we_n    = bus.hwrite;
                    mem_addr_n  = bus.haddr[SDRAM_AW-1:2];
                    mem_be_n    = be_dec;
                    hreadyout_n = 1'b0;
                    if (illegal) begin
                        state_n = ERR1;
                        hresp_n = 1'b1;
                    end else if (bus.hwrite) begin
                        state_n = WDATA;
                    end else begin
                        state_n   = REQ;
                        mem_req_n = 1'b1;
                    end
                end
            end
            ERR1: begin
                state_n     = ERR2;
                hreadyout_n = 1'b1;
                hresp_n     = 1'b1;
            end
            WDATA: begin
                // hwdata is only valid now, so the write request starts here.
                mem_wdata_n = bus.hwdata;
                mem_req_n   = 1'b1;
                mem_we_n    = 1'b1;
                state_n     = REQ;
            end
            REQ: begin
                if (bus.mem_ack) begin
                    mem_req_n = 1'b0;
                    if (mem_we_q) begin
                        hreadyout_n = 1'b1;
                        state_n     = IDLE;
                    end else if (bus.mem_rvalid) begin
                        hrdata_n    = bus.mem_rdata;
                        hreadyout_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        state_n = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (bus.mem_rvalid) begin
                    hrdata_n    = bus.mem_rdata;
                    hreadyout_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset withdraws any pending request at once.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_n;
            hreadyout_q <= hreadyout_n;
            hresp_q     <= hresp_n;
            hrdata_q    <= hrdata_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_be_q    <= mem_be_n;
            mem_wdata_q <= mem_wdata_n;
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_ahb_sdram_bridge.sv
// Bench for ahb_sdram_bridge: table of single transfers plus hand-written
// idle/busy, back-to-back and reset-mid-request sequences. A core model
// answers requests and checks them against a queue of expected transactions.
module tb_ahb_sdram_bridge;
    localparam int HAW      = 32;
    localparam int SDRAM_AW = 24;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_sdram_bridge_if #(.HAW(HAW), .SDRAM_AW(SDRAM_AW)) bif ();

    ahb_sdram_bridge #(.HAW(HAW), .SDRAM_AW(SDRAM_AW)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bif)
    );

    typedef struct {
        logic                we;
        logic [SDRAM_AW-3:0] addr;
        logic [3:0]          be;
        logic [31:0]         wdata;
        logic [31:0]         rdata;
    } mem_txn_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          rv_dly;
        logic [3:0]  be;
        logic        err;
        int          waits;
    } vec_t;

    int checks = 0;
    int errors = 0;

    mem_txn_t    mem_q[$];
    int          ack_dly = 0;
    int          rv_dly  = 0;
    int          wait_cnt = 0;
    int          rv_cnt = 0;
    bit          pend_rd = 0;
    bit          acked_last = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] last_rd = '0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // SDRAM core model: acks after ack_dly request cycles, returns read data rv_dly cycles after ack.
    initial begin
        mem_txn_t t;
        bif.mem_ack    = 1'b0;
        bif.mem_rvalid = 1'b0;
        bif.mem_rdata  = 32'hBAD0BAD0;
        forever begin
            @(negedge hclk);
            bif.mem_ack    = 1'b0;
            bif.mem_rvalid = 1'b0;
            bif.mem_rdata  = 32'hBAD0BAD0;
            if (!hresetn) begin
                wait_cnt   = 0;
                pend_rd    = 0;
                acked_last = 0;
            end else begin
                if (acked_last) chk("req_drop_after_ack", 32'(bif.mem_req), 32'd0);
                acked_last = 0;
                if (pend_rd) begin
                    if (rv_cnt == 0) begin
                        bif.mem_rvalid = 1'b1;
                        bif.mem_rdata  = pend_data;
                        pend_rd        = 0;
                    end else begin
                        rv_cnt--;
                    end
                end else if (bif.mem_req) begin
                    if (wait_cnt < ack_dly) begin
                        wait_cnt++;
                    end else begin
                        wait_cnt    = 0;
                        bif.mem_ack = 1'b1;
                        acked_last  = 1;
                        if (mem_q.size() == 0) begin
                            chk("unexpected_req", 32'(bif.mem_req), 32'd0);
                        end else begin
                            t = mem_q.pop_front();
                            chk("mem_we", 32'(bif.mem_we), 32'(t.we));
                            chk("mem_addr", 32'(bif.mem_addr), 32'(t.addr));
                            chk("mem_be", 32'(bif.mem_be), 32'(t.be));
                            if (t.we) begin
                                chk("mem_wdata", bif.mem_wdata, t.wdata);
                            end else if (rv_dly == 0) begin
                                bif.mem_rvalid = 1'b1;
                                bif.mem_rdata  = t.rdata;
                            end else begin
                                pend_rd   = 1;
                                rv_cnt    = rv_dly - 1;
                                pend_data = t.rdata;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic idle_bus();
        bif.hsel   = 1'b0;
        bif.htrans = 2'd0;
        bif.hwrite = 1'b0;
        bif.hsize  = 3'd0;
        bif.haddr  = '0;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic write, input logic [2:0] size);
        bif.hsel   = 1'b1;
        bif.htrans = 2'd2;
        bif.haddr  = addr;
        bif.hwrite = write;
        bif.hsize  = size;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic write, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        mem_txn_t t;
        t.we    = write;
        t.addr  = addr[SDRAM_AW-1:2];
        t.be    = be;
        t.wdata = wdata;
        t.rdata = rdata;
        mem_q.push_back(t);
    endtask

    // Watch one data phase to completion; returns just after the edge that ends it.
    task automatic data_phase(input string name, input logic err, input logic rd,
                              input logic [31:0] exp_rdata, input int exp_waits);
        int waits = 0;
        bit done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge hclk);
            if (bif.hreadyout) begin
                done = 1;
                chk({name, "_hresp"}, 32'(bif.hresp), 32'(err));
                chk({name, "_waits"}, 32'(waits), 32'(exp_waits));
                if (rd && !err) begin
                    chk({name, "_hrdata"}, bif.hrdata, exp_rdata);
                    last_rd = exp_rdata;
                end else begin
                    chk({name, "_hrdata_hold"}, bif.hrdata, last_rd);
                end
            end else begin
                chk({name, "_wait_hresp"}, 32'(bif.hresp), 32'(err));
                waits++;
            end
        end
        if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
        @(posedge hclk); #1;
    endtask

    task automatic xfer(input string name, input vec_t v);
        ack_dly = v.ack_dly;
        rv_dly  = v.rv_dly;
        if (!v.err) push_exp(v.addr, v.write, v.be, v.wdata, v.rdata);
        addr_phase(v.addr, v.write, v.size);
        @(posedge hclk); #1;
        idle_bus();
        bif.hwdata = v.wdata;
        data_phase(name, v.err, !v.write, v.rdata, v.waits);
    endtask

    initial begin
        //           addr          wr    sz    wdata         rdata         ack rv be       err   waits
        vecs[0] = '{32'h0000_0010, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 1'b0, 2};
        vecs[1] = '{32'h0000_0013, 1'b0, 3'd0, 32'h0,        32'h11223344, 3, 2, 4'b1000, 1'b0, 6};
        vecs[2] = '{32'h0000_0002, 1'b1, 3'd2, 32'h0,        32'h0,        0, 0, 4'b0000, 1'b1, 1};
        vecs[3] = '{32'h0000_0000, 1'b0, 3'd3, 32'h0,        32'h0,        0, 0, 4'b0000, 1'b1, 1};
        vecs[4] = '{32'h0000_0022, 1'b1, 3'd1, 32'hCAFEF00D, 32'h0,        1, 0, 4'b1100, 1'b0, 3};
        vecs[5] = '{32'h0000_0020, 1'b0, 3'd1, 32'h0,        32'hA5A55A5A, 0, 0, 4'b0011, 1'b0, 1};
        vecs[6] = '{32'h0000_0021, 1'b0, 3'd1, 32'h0,        32'h0,        0, 0, 4'b0000, 1'b1, 1};
        vecs[7] = '{32'h0000_0101, 1'b1, 3'd0, 32'h0000AB00, 32'h0,        2, 0, 4'b0010, 1'b0, 4};
        vecs[8] = '{32'hFF00_0010, 1'b0, 3'd2, 32'h0,        32'h01234567, 1, 0, 4'b1111, 1'b0, 2};
        vecs[9] = '{32'h0000_0012, 1'b0, 3'd0, 32'h0,        32'h55667788, 0, 1, 4'b0100, 1'b0, 2};

        idle_bus();
        bif.hready = 1'b1;
        bif.hwdata = '0;

        // Reset values
        @(negedge hclk);
        @(negedge hclk);
        chk("rst_hreadyout", 32'(bif.hreadyout), 32'd1);
        chk("rst_hresp", 32'(bif.hresp), 32'd0);
        chk("rst_hrdata", bif.hrdata, 32'd0);
        chk("rst_mem_req", 32'(bif.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bif.mem_addr), 32'd0);
        chk("rst_mem_be", 32'(bif.mem_be), 32'd0);
        chk("rst_mem_wdata", bif.mem_wdata, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Single transfers from the table
        for (int i = 0; i < 10; i++) xfer($sformatf("vec%0d", i), vecs[i]);

        // IDLE, BUSY, hready low and hsel low must all be ignored
        for (int i = 0; i < 20; i++) begin
            bif.hsel   = (i < 15) ? 1'b1 : 1'b0;
            bif.hready = (i >= 10 && i < 15) ? 1'b0 : 1'b1;
            bif.htrans = (i < 5) ? 2'd0 : (i < 10) ? 2'd1 : 2'd2;
            bif.haddr  = 32'h40;
            bif.hwrite = 1'b1;
            bif.hsize  = 3'd2;
            @(negedge hclk);
            chk($sformatf("noacc%0d_hreadyout", i), 32'(bif.hreadyout), 32'd1);
            chk($sformatf("noacc%0d_hresp", i), 32'(bif.hresp), 32'd0);
            chk($sformatf("noacc%0d_mem_req", i), 32'(bif.mem_req), 32'd0);
            @(posedge hclk); #1;
        end
        idle_bus();
        bif.hready = 1'b1;
        @(negedge hclk);
        chk("noacc_end_hreadyout", 32'(bif.hreadyout), 32'd1);
        chk("noacc_end_mem_req", 32'(bif.mem_req), 32'd0);
        @(posedge hclk); #1;

        // Back-to-back: read address phase sits in the write's completing cycle
        ack_dly = 0;
        rv_dly  = 0;
        push_exp(32'h100, 1'b1, 4'b1111, 32'h12345678, 32'h0);
        push_exp(32'h104, 1'b0, 4'b1111, 32'h0, 32'h9ABCDEF0);
        addr_phase(32'h100, 1'b1, 3'd2);
        @(posedge hclk); #1;
        addr_phase(32'h104, 1'b0, 3'd2);
        bif.hwdata = 32'h12345678;
        data_phase("b2b_wr", 1'b0, 1'b0, 32'h0, 2);
        idle_bus();
        data_phase("b2b_rd", 1'b0, 1'b1, 32'h9ABCDEF0, 1);

        // Reset while the core withholds ack
        ack_dly = 1000;
        push_exp(32'h200, 1'b1, 4'b1111, 32'hFEEDFACE, 32'h0);
        addr_phase(32'h200, 1'b1, 3'd2);
        @(posedge hclk); #1;
        idle_bus();
        bif.hwdata = 32'hFEEDFACE;
        @(posedge hclk); #1;
        chk("rstreq_mem_req_before", 32'(bif.mem_req), 32'd1);
        chk("rstreq_hreadyout_before", 32'(bif.hreadyout), 32'd0);
        #2;
        hresetn = 1'b0;
        #1;
        chk("rstreq_mem_req", 32'(bif.mem_req), 32'd0);
        chk("rstreq_hreadyout", 32'(bif.hreadyout), 32'd1);
        chk("rstreq_hresp", 32'(bif.hresp), 32'd0);
        mem_q.delete();
        last_rd = '0;
        ack_dly = 0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer("post_rst_wr", '{32'h0000_0300, 1'b1, 3'd2, 32'h0BADF00D, 32'h0, 0, 0, 4'b1111, 1'b0, 2});

        @(posedge hclk); #1;
        chk("sb_empty", 32'(mem_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
